retro_catc_stall_bridge: RTL and testbench



---
 rtl/retro_catc_stall_bridge.sv | 181 ++++++++++++++++++
 tb/tb_retro_catc_stall_bridge.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retro_catc_stall_bridge.sv
// Core-side memory bridge: stalls the CATC tick while a read is outstanding.
// Optional stall statistics are built when RETRO_CATC_STALL_STATS_EN is defined.
module retro_catc_stall_bridge #(
    parameter int AddrBits      = 16,
    parameter int DataBits      = 8,
    parameter int TimeoutCycles = 4096
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                ClkEn,
    input  logic                CoreReq,
    input  logic                CoreWrite,
    input  logic [AddrBits-1:0] CoreAddr,
    input  logic [DataBits-1:0] CoreWData,
    output logic [DataBits-1:0] CoreRData,
    output logic                Delay,
    output logic                MemReq,
    output logic                MemWrite,
    output logic [AddrBits-1:0] MemAddr,
    output logic [DataBits-1:0] MemWData,
    input  logic                MemAck,
    input  logic [DataBits-1:0] MemRData,
    output logic                TimedOut,
    output logic [31:0]         StallCycles,
    output logic [15:0]         StallEvents
);
    localparam int TW = $clog2(TimeoutCycles) + 1;
    localparam logic [TW-1:0] TLast = TW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, POST, READ, DRAIN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_pend_valid;
    logic                w_pend_nxt;
    logic                r_pend_write;
    logic [AddrBits-1:0] r_pend_addr;
    logic [DataBits-1:0] r_pend_wdata;
    logic                r_mem_req;
    logic                r_mem_write;
    logic [AddrBits-1:0] r_mem_addr;
    logic [DataBits-1:0] r_mem_wdata;
    logic [DataBits-1:0] r_rdata;
    logic                r_delay;
    logic                r_timed_out;
    logic [TW-1:0]       r_tcnt;

    logic                w_acc;
    logic                w_slot;
    logic                w_in_read;
    logic                w_issue_pend;
    logic                w_issue_new;
    logic                w_issue;
    logic                w_park;
    logic                w_read_done;
    logic                w_fin;
    logic                w_timeout;
    logic                w_delay_nxt;
    logic                w_iss_write;
    logic [AddrBits-1:0] w_iss_addr;
    logic [DataBits-1:0] w_iss_wdata;

    assign w_acc       = ClkEn & CoreReq;
    assign w_slot      = (r_state == POST) | (r_state == DRAIN);
    assign w_in_read   = (r_state == READ);

    // Event decode; every term below is mutually exclusive.
    assign w_issue_pend = w_slot & MemAck & r_pend_valid;
    assign w_issue_new  = ((r_state == IDLE) & w_acc)
                        | (w_slot & MemAck & ~r_pend_valid & w_acc);
    assign w_park       = w_slot & ~MemAck & ~r_pend_valid & w_acc;
    assign w_read_done  = w_in_read & MemAck;
    assign w_fin        = (w_slot & MemAck & ~r_pend_valid & ~w_acc)
                        | w_read_done;
    assign w_timeout    = w_in_read & ~MemAck & (r_tcnt == TLast);
    assign w_issue      = w_issue_pend | w_issue_new;

    assign w_iss_write = w_issue_pend ? r_pend_write : CoreWrite;
    assign w_iss_addr  = w_issue_pend ? r_pend_addr  : CoreAddr;
    assign w_iss_wdata = w_issue_pend ? r_pend_wdata : CoreWData;

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend_valid;
        unique case (1'b1)
            w_issue_pend: begin
                w_state_nxt = r_pend_write ? POST : READ;
                w_pend_nxt  = 1'b0;
            end
            w_issue_new: w_state_nxt = CoreWrite ? POST : READ;
            w_park:      w_pend_nxt  = 1'b1;
            w_fin:       w_state_nxt = IDLE;
            w_timeout:   w_state_nxt = DRAIN;
            default: ;
        endcase
    end

    assign w_delay_nxt = (w_state_nxt == READ) | w_pend_nxt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_pend_valid <= 1'b0;
            r_pend_write <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_wdata <= '0;
            r_mem_req    <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdata      <= '0;
            r_delay      <= 1'b0;
            r_timed_out  <= 1'b0;
            r_tcnt       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_valid <= w_pend_nxt;
            r_delay      <= w_delay_nxt;
            if (w_park) begin
                r_pend_write <= CoreWrite;
                r_pend_addr  <= CoreAddr;
                r_pend_wdata <= CoreWData;
            end
            if (w_issue) begin
                r_mem_req   <= 1'b1;
                r_mem_write <= w_iss_write;
                r_mem_addr  <= w_iss_addr;
                r_mem_wdata <= w_iss_wdata;
                r_tcnt      <= '0;
            end else begin
                if (w_fin) begin
                    r_mem_req <= 1'b0;
                end
                if (w_in_read) begin
                    r_tcnt <= r_tcnt + TW'(1);
                end
            end
            // An ack in the timeout cycle wins: w_timeout excludes MemAck.
            if (w_read_done) begin
                r_rdata <= MemRData;
            end else if (w_timeout) begin
                r_rdata     <= '1;
                r_timed_out <= 1'b1;
            end
        end
    end

    assign CoreRData = r_rdata;
    assign Delay     = r_delay;
    assign MemReq    = r_mem_req;
    assign MemWrite  = r_mem_write;
    assign MemAddr   = r_mem_addr;
    assign MemWData  = r_mem_wdata;
    assign TimedOut  = r_timed_out;

`ifdef RETRO_CATC_STALL_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_stall_events;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_cycles <= '0;
            r_stall_events <= '0;
        end else begin
            if (r_delay && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_delay_nxt && !r_delay && (r_stall_events != '1)) begin
                r_stall_events <= r_stall_events + 16'd1;
            end
        end
    end

    assign StallCycles = r_stall_cycles;
    assign StallEvents = r_stall_events;
`else
    assign StallCycles = '0;
    assign StallEvents = '0;
`endif

endmodule

// File: tb/tb_retro_catc_stall_bridge.sv
// Scoreboard bench for retro_catc_stall_bridge: directed timing cases plus
// randomized traffic checked against a transaction-level memory model.
`timescale 1ns/1ps
module tb_retro_catc_stall_bridge;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          ClkEn = 1'b0;
    logic          CoreReq = 1'b0;
    logic          CoreWrite = 1'b0;
    logic [AW-1:0] CoreAddr = '0;
    logic [DW-1:0] CoreWData = '0;
    logic [DW-1:0] CoreRData;
    logic          Delay;
    logic          MemReq;
    logic          MemWrite;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWData;
    logic          MemAck = 1'b0;
    logic [DW-1:0] MemRData = '0;
    logic          TimedOut;
    logic [31:0]   StallCycles;
    logic [15:0]   StallEvents;

    always #5 Clk = ~Clk;

    retro_catc_stall_bridge #(
        .AddrBits(AW), .DataBits(DW), .TimeoutCycles(TO)
    ) dut (
        .Clk(Clk), .Reset(Reset), .ClkEn(ClkEn), .CoreReq(CoreReq),
        .CoreWrite(CoreWrite), .CoreAddr(CoreAddr), .CoreWData(CoreWData),
        .CoreRData(CoreRData), .Delay(Delay), .MemReq(MemReq),
        .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemAck(MemAck), .MemRData(MemRData), .TimedOut(TimedOut),
        .StallCycles(StallCycles), .StallEvents(StallEvents)
    );

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            lat;
    } req_t;

    typedef struct {
        logic [DW-1:0] d;
        bit            to;
    } rd_t;

    req_t          exp_req[$];
    rd_t           exp_rd[$];
    logic [DW-1:0] ref_mem[int];
    logic [DW-1:0] sim_mem[int];
    int            n_cmp = 0;
    int            n_err = 0;
    bit            exp_to = 0;
    longint        dly_cnt = 0;
    longint        mrq_cnt = 0;
    longint        wmatch_cnt = 0;

    function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not seen within bound", nm);
    endtask

    // The CATC never ticks a stalled core.
    always @(posedge Clk)
        if (!Reset && ClkEn && CoreReq)
            assert (!Delay) else $error("request issued while core stalled");

    // Memory responder and scoreboard monitor.
    initial begin : mon
        bit   serving = 0;
        bit   chk = 0;
        int   left = 0;
        req_t cur;
        rd_t  er;
        forever begin
            @(negedge Clk);
            MemAck = 1'b0;
            if (Delay) dly_cnt++;
            if (MemReq) mrq_cnt++;
            if (MemReq && MemWrite && MemAddr == 16'h2000 && MemWData == 8'h33)
                wmatch_cnt++;
            if (Reset) begin
                serving = 0;
                chk = 0;
            end else begin
                if (chk) begin
                    chk = 0;
                    if (exp_rd.size() == 0) begin
                        fail_now("read_result_unexpected");
                    end else begin
                        er = exp_rd.pop_front();
                        check("rdata", CoreRData, er.d);
                        if (!er.to) check("delay_after_read", Delay, 0);
                    end
                end
                if (MemReq && !serving) begin
                    serving = 1;
                    if (exp_req.size() == 0) begin
                        fail_now("memreq_unexpected");
                        cur.w = MemWrite;
                        cur.lat = 0;
                    end else begin
                        cur = exp_req.pop_front();
                        check("mem_write", MemWrite, cur.w);
                        check("mem_addr", MemAddr, cur.a);
                        if (cur.w) check("mem_wdata", MemWData, cur.d);
                    end
                    left = cur.lat;
                end
                if (serving) begin
                    if (left == 0) begin
                        MemAck = 1'b1;
                        serving = 0;
                        if (MemWrite) begin
                            sim_mem[int'(MemAddr)] = MemWData;
                        end else begin
                            MemRData = sim_mem.exists(int'(MemAddr)) ?
                                       sim_mem[int'(MemAddr)] : init_val(MemAddr);
                            chk = 1;
                        end
                    end else begin
                        left--;
                    end
                end
            end
        end
    end

    task automatic issue(bit w, logic [AW-1:0] a, logic [DW-1:0] d, int lat);
        req_t r;
        rd_t  e;
        int   g = 0;
        @(negedge Clk);
        while (Delay && g < 300) begin
            @(negedge Clk);
            g++;
        end
        if (Delay) begin
            fail_now("issue_stall_bound");
            return;
        end
        ClkEn = 1'b1;
        CoreReq = 1'b1;
        CoreWrite = w;
        CoreAddr = a;
        CoreWData = d;
        r = '{w, a, d, lat};
        exp_req.push_back(r);
        if (w) begin
            ref_mem[int'(a)] = d;
        end else begin
            e.to = (lat + 1 > TO);
            e.d = e.to ? 8'hFF :
                  (ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a));
            if (e.to) exp_to = 1;
            exp_rd.push_back(e);
        end
        @(negedge Clk);
        ClkEn = 1'b0;
        CoreReq = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((MemReq || Delay || exp_req.size() != 0) && g < 3000) begin
            @(negedge Clk);
            g++;
        end
        if (g >= 3000) fail_now("idle_bound");
        repeat (2) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        ClkEn = 1'b0;
        CoreReq = 1'b0;
        exp_req.delete();
        exp_rd.delete();
        ref_mem.delete();
        sim_mem.delete();
        exp_to = 0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin : stim
        longint d0;
        longint m0;
        longint w0;
        do_reset();
        @(negedge Clk);
        check("rst_delay", Delay, 0);
        check("rst_memreq", MemReq, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_timedout", TimedOut, 0);
        check("rst_rdata", CoreRData, 0);
        check("rst_memaddr", MemAddr, 0);
        check("rst_memwdata", MemWData, 0);
        check("rst_stallcycles", StallCycles, 0);
        check("rst_stallevents", StallEvents, 0);

        // Read with four idle cycles before the ack: five stall cycles.
        d0 = dly_cnt;
        issue(0, 16'h0000, 8'h00, 4);
        wait_idle();
        check("read_stall", dly_cnt - d0, 5);
        check("read_data", CoreRData, 8'h5A);

        // Posted write never stalls; fields held through the ack cycle.
        d0 = dly_cnt;
        w0 = wmatch_cnt;
        issue(1, 16'h2000, 8'h33, 9);
        wait_idle();
        check("write_stall", dly_cnt - d0, 0);
        check("write_hold", wmatch_cnt - w0, 10);

        // Read queued behind a posted write.
        d0 = dly_cnt;
        m0 = mrq_cnt;
        issue(1, 16'h0040, 8'hC3, 6);
        issue(0, 16'h0040, 8'h00, 3);
        wait_idle();
        check("pend_stall", dly_cnt - d0, 9);
        check("pend_memreq", mrq_cnt - m0, 11);
        check("pend_data", CoreRData, 8'hC3);

        // Ack lands in the timeout cycle: data wins.
        issue(1, 16'h0100, 8'h11, 0);
        wait_idle();
        d0 = dly_cnt;
        issue(0, 16'h0100, 8'h00, TO - 1);
        wait_idle();
        check("edge_stall", dly_cnt - d0, TO);
        check("edge_data", CoreRData, 8'h11);
        check("edge_timedout", TimedOut, 0);

        // Timeout, then a late ack drains back to idle.
        d0 = dly_cnt;
        issue(0, 16'h0101, 8'h00, 40);
        repeat (TO + 2) @(negedge Clk);
        check("to_rdata", CoreRData, 8'hFF);
        check("to_flag", TimedOut, 1);
        check("to_delay", Delay, 0);
        check("to_memreq_held", MemReq, 1);
        wait_idle();
        check("to_stall", dly_cnt - d0, TO);
        check("to_rdata_after", CoreRData, 8'hFF);

        // Statistics: stalls of 3 and 7 cycles.
        do_reset();
        issue(0, 16'h0001, 8'h00, 2);
        wait_idle();
        issue(0, 16'h0002, 8'h00, 6);
        wait_idle();
`ifdef RETRO_CATC_STALL_STATS_EN
        check("stat_cycles", StallCycles, 10);
        check("stat_events", StallEvents, 2);
`else
        check("stat_cycles", StallCycles, 0);
        check("stat_events", StallEvents, 0);
`endif

        // Reset in the middle of a read.
        issue(0, 16'h0003, 8'h00, 40);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        exp_req.delete();
        exp_rd.delete();
        exp_to = 0;
        @(negedge Clk);
        check("mid_rst_delay", Delay, 0);
        check("mid_rst_memreq", MemReq, 0);
        check("mid_rst_rdata", CoreRData, 0);
        check("mid_rst_memaddr", MemAddr, 0);
        check("mid_rst_stall", StallCycles, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Randomized traffic over a small address window.
        for (int i = 0; i < 150; i++) begin
            int lat;
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 2, TO + 6))
                                               : int'($urandom_range(0, 5));
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                  DW'($urandom), lat);
        end
        wait_idle();
        check("final_timedout", TimedOut, exp_to);
        check("final_req_left", exp_req.size(), 0);
        check("final_rd_left", exp_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
